// File: rtl/bus_pkg.sv
// Shared definitions for the CPU memory-bus responder: FSM encoding and fixed data words.
// Optional feature macro: BUS_MEM_OOR_FAULT_EN (poisoned out-of-range reads).
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } bus_state_t;

    localparam logic [31:0] BUS_POISON_WORD = 32'hDEAD_BEEF;
    localparam logic [31:0] BUS_RESET_READ  = 32'h0000_0000;
    localparam int          BUS_WAIT_W      = 4;

    typedef logic [BUS_WAIT_W-1:0] wait_cnt_t;

    // Value returned to the CPU when a read misses the RAM window.
    function automatic logic [31:0] oor_read_value();
`ifdef BUS_MEM_OOR_FAULT_EN
        return BUS_POISON_WORD;
`else
        return BUS_RESET_READ;
`endif
    endfunction

endpackage

// File: rtl/bus_mem_ram.sv
// Single-port synchronous word RAM; dout registers one cycle after an enabled access.
// Kept as its own module so the array can be swapped for the hard macro.
module bus_mem_ram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Target end of the CPU memory bus: serves re/we pulses against a word RAM with mem_busy throttling.
// Optional feature macro: BUS_MEM_OOR_FAULT_EN (sticky out-of-range fault capture).
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        re,
    input  logic        we,
    output logic [31:0] read_data,
    output logic        mem_busy,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [32:0] BASE_33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_33 = BASE_33 + 33'(4 * DEPTH);

    bus_state_t    state, state_next;
    wait_cnt_t     cnt, cnt_next;
    logic          busy_next;
    logic          req;
    logic          req_in_range;
    logic [AW-1:0] req_idx;
    logic          kind_write;
    logic          in_range_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          ram_en;
    logic [31:0]   ram_dout;

    assign req = (state == IDLE) && (re || we);

    // 33-bit window test so a window ending at 2^32 cannot wrap.
    assign req_in_range = ({1'b0, address} >= BASE_33) && ({1'b0, address} < LIMIT_33);
    assign req_idx      = AW'((address - BASE_ADDR) >> 2);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_next  = mem_busy;
        case (state)
            IDLE: begin
                if (re || we) begin
                    busy_next = 1'b1;
                    cnt_next  = wait_cnt_t'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - wait_cnt_t'(1);
                if (cnt == wait_cnt_t'(1)) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = DONE;
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_busy   <= 1'b0;
            read_data  <= BUS_RESET_READ;
            kind_write <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            mem_busy <= busy_next;
            if (req) begin
                kind_write <= we;
                in_range_q <= req_in_range;
                idx_q      <= req_idx;
                wdata_q    <= write_data;
            end
            if (state == DONE && !kind_write) begin
                read_data <= in_range_q ? ram_dout : oor_read_value();
            end
        end
    end

    // Gating with rst drops a write whose ACCESS cycle coincides with reset.
    assign ram_en = (state == ACCESS) && in_range_q && !rst;

    bus_mem_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk (clk),
        .en  (ram_en),
        .wen (kind_write),
        .addr(idx_q),
        .din (wdata_q),
        .dout(ram_dout)
    );

`ifdef BUS_MEM_OOR_FAULT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (req && !req_in_range && !fault) begin
            fault      <= 1'b1;
            fault_addr <= address;
        end
    end
`else
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: three instances with WAIT_STATES 0, 1 and 3.
// Expected values adapt to BUS_MEM_OOR_FAULT_EN when it is defined for the build.
module tb_bus_mem_responder;

`ifdef BUS_MEM_OOR_FAULT_EN
    localparam logic [31:0] OOR_RD = 32'hDEAD_BEEF;
    localparam logic        FLT    = 1'b1;
`else
    localparam logic [31:0] OOR_RD = 32'h0000_0000;
    localparam logic        FLT    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address    [3];
    logic [31:0] write_data [3];
    logic        re         [3];
    logic        we         [3];
    logic [31:0] read_data  [3];
    logic        mem_busy   [3];
    logic        fault      [3];
    logic [31:0] fault_addr [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .address(address[0]), .write_data(write_data[0]),
        .re(re[0]), .we(we[0]), .read_data(read_data[0]), .mem_busy(mem_busy[0]),
        .fault(fault[0]), .fault_addr(fault_addr[0])
    );
    bus_mem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .address(address[1]), .write_data(write_data[1]),
        .re(re[1]), .we(we[1]), .read_data(read_data[1]), .mem_busy(mem_busy[1]),
        .fault(fault[1]), .fault_addr(fault_addr[1])
    );
    bus_mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .address(address[2]), .write_data(write_data[2]),
        .re(re[2]), .we(we[2]), .read_data(read_data[2]), .mem_busy(mem_busy[2]),
        .fault(fault[2]), .fault_addr(fault_addr[2])
    );

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        oor;
        logic [31:0] rd;
        logic        flt;
        logic [31:0] faddr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One request pulse; returns how many consecutive cycles mem_busy stayed high.
    task automatic do_access(input int i, input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, output int nbusy);
        @(posedge clk); #1;
        re[i] = r; we[i] = w; address[i] = a; write_data[i] = d;
        @(posedge clk); #1;
        re[i] = 1'b0; we[i] = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_busy[i]) nbusy++;
            else break;
        end
    endtask

    task automatic rmw(input int i, input int ws);
        int          nb;
        logic [31:0] merged;
        do_access(i, 1'b0, 1'b1, 32'h4020, 32'h0000_00FF, nb);
        check($sformatf("rmw%0d wr busy", ws), 32'(nb), 32'(ws + 2));
        do_access(i, 1'b1, 1'b0, 32'h4020, 32'h0, nb);
        check($sformatf("rmw%0d rd busy", ws), 32'(nb), 32'(ws + 2));
        check($sformatf("rmw%0d rd1", ws), read_data[i], 32'h0000_00FF);
        merged = (read_data[i] & ~32'h0000_FF00) | 32'h0000_AB00;
        do_access(i, 1'b0, 1'b1, 32'h4020, merged, nb);
        check($sformatf("rmw%0d wr2 keeps rd", ws), read_data[i], 32'h0000_00FF);
        do_access(i, 1'b1, 1'b0, 32'h4021, 32'h0, nb);
        check($sformatf("rmw%0d rd2", ws), read_data[i], 32'h0000_ABFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nb;
        logic [31:0] exp_rd;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_4000, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_4FFC, 32'hCAFE_F00D, 1'b0, 32'h1234_5678, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_4FFC, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_4002, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_5000, 32'h1111_2222, 1'b0, 32'h1234_5678, 1'b1, 32'h5000};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0,         1'b1, 32'h0,         1'b1, 32'h5000};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,         1'b1, 32'h5000};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         1'b0, 32'h1234_5678, 1'b1, 32'h5000};

        for (int i = 0; i < 3; i++) begin
            re[i] = 1'b0; we[i] = 1'b0; address[i] = '0; write_data[i] = '0;
        end

        // Reset held two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset busy%0d", i), {31'b0, mem_busy[i]}, 32'h0);
            check($sformatf("reset rd%0d", i), read_data[i], 32'h0);
            check($sformatf("reset fault%0d", i), {31'b0, fault[i]}, 32'h0);
            check($sformatf("reset faddr%0d", i), fault_addr[i], 32'h0);
        end

        // Table of single accesses on the WAIT_STATES=1 instance.
        for (int v = 0; v < 9; v++) begin
            do_access(1, vecs[v].re, vecs[v].we, vecs[v].addr, vecs[v].wdata, nb);
            exp_rd = vecs[v].oor ? OOR_RD : vecs[v].rd;
            check($sformatf("v%0d busy", v), 32'(nb), 32'd3);
            check($sformatf("v%0d rd", v), read_data[1], exp_rd);
            check($sformatf("v%0d fault", v), {31'b0, fault[1]}, {31'b0, FLT & vecs[v].flt});
            check($sformatf("v%0d faddr", v), fault_addr[1], FLT ? vecs[v].faddr : 32'h0);
        end

        // read_data holds through idle cycles.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("hold rd%0d", k), read_data[1], 32'h1234_5678);
        end

        // re+we together behaves as a write.
        do_access(1, 1'b1, 1'b1, 32'h4008, 32'hA5A5_A5A5, nb);
        check("rewe busy", 32'(nb), 32'd3);
        check("rewe rd unchanged", read_data[1], 32'h1234_5678);
        do_access(1, 1'b1, 1'b0, 32'h4008, 32'h0, nb);
        check("rewe readback", read_data[1], 32'hA5A5_A5A5);

        // A re pulse during busy must be ignored.
        @(posedge clk); #1;
        we[1] = 1'b1; address[1] = 32'h400C; write_data[1] = 32'h0000_0077;
        @(posedge clk); #1;
        we[1] = 1'b0; re[1] = 1'b1; address[1] = 32'h4000;
        @(posedge clk); #1;
        re[1] = 1'b0;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_busy[1]) nb++;
            else break;
        end
        check("busy-re remaining busy", 32'(nb), 32'd2);
        check("busy-re rd", read_data[1], 32'hA5A5_A5A5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("busy-re idle%0d", k), {31'b0, mem_busy[1]}, 32'h0);
        end
        do_access(1, 1'b1, 1'b0, 32'h400C, 32'h0, nb);
        check("busy-re write committed", read_data[1], 32'h0000_0077);

        // Reset during the WAIT cycle of a write drops it.
        do_access(1, 1'b0, 1'b1, 32'h4010, 32'h0101_0101, nb);
        @(posedge clk); #1;
        we[1] = 1'b1; address[1] = 32'h4010; write_data[1] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        we[1] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort busy", {31'b0, mem_busy[1]}, 32'h0);
        check("abort rd", read_data[1], 32'h0);
        check("abort fault", {31'b0, fault[1]}, 32'h0);
        do_access(1, 1'b1, 1'b0, 32'h4010, 32'h0, nb);
        check("abort busy len", 32'(nb), 32'd3);
        check("abort word kept", read_data[1], 32'h0101_0101);

        // Below-base access, then a later out-of-range access.
        do_access(1, 1'b1, 1'b0, 32'h3FFC, 32'h0, nb);
        check("below busy", 32'(nb), 32'd3);
        check("below rd", read_data[1], OOR_RD);
        check("below fault", {31'b0, fault[1]}, {31'b0, FLT});
        check("below faddr", fault_addr[1], FLT ? 32'h3FFC : 32'h0);
        do_access(1, 1'b1, 1'b0, 32'h9000, 32'h0, nb);
        check("second oor faddr", fault_addr[1], FLT ? 32'h3FFC : 32'h0);
        do_access(1, 1'b1, 1'b0, 32'h4010, 32'h0, nb);
        check("fault sticky", {31'b0, fault[1]}, {31'b0, FLT});
        check("in-range after oor", read_data[1], 32'h0101_0101);

        // CPU read-modify-write sequences at other wait-state settings.
        rmw(0, 0);
        rmw(2, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
